// File: rtl/cam_frame_sched_if.sv
// Signal bundle between the camera frame sequencer and its surroundings.
// The environment side is master; the sequencer side (cam_frame_sched) is slave.
interface cam_frame_sched_if #(
  parameter int ADDR_W = 19
);
  logic              cfg_done;
  logic              cmos_vsyn;
  logic              frame_en;
  logic              proc_done;
  logic              data_16b_en;
  logic              capture_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic              frame_start;
  logic              frame_end;
  logic              frame_err;
  logic              busy;

  modport master (
    output cfg_done, cmos_vsyn, frame_en, proc_done, data_16b_en,
    input  capture_en, wr_addr, wr_en, frame_start, frame_end, frame_err, busy
  );

  modport slave (
    input  cfg_done, cmos_vsyn, frame_en, proc_done, data_16b_en,
    output capture_en, wr_addr, wr_en, frame_start, frame_end, frame_err, busy
  );
endinterface

// File: rtl/cam_frame_sched.sv
// Frame-level capture sequencer in the cmos_pclk domain: warm-up, debounced request,
// one VSYNC-aligned frame of capture, write addressing. Define FRAME_CHECK_EN for word-count checking.
module cam_frame_sched #(
  parameter int SKIP_FRAMES = 30,
  parameter int DEBOUNCE    = 100,
  parameter int FRAME_WORDS = 307200,
  parameter int ADDR_W      = 19
) (
  input  logic             cmos_pclk,
  input  logic             rst_n,
  cam_frame_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_READY,
    S_ARM,
    S_CAPTURE,
    S_WAIT_PROC
  } state_e;

  localparam int SKIP_W = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);
  localparam int DEB_W = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  if (FRAME_WORDS > (2 ** ADDR_W)) begin : g_bad_frame_words
    $error("FRAME_WORDS does not fit in the ADDR_W address space");
  end

  state_e            state_q,       state_d;
  logic              cfg_meta_q,    cfg_meta_d;
  logic              cfg_sync_q,    cfg_sync_d;
  logic              vsyn_d1_q,     vsyn_d1_d;
  logic              vsyn_d2_q,     vsyn_d2_d;
  logic [DEB_W-1:0]  deb_cnt_q,     deb_cnt_d;
  logic              consumed_q,    consumed_d;
  logic [SKIP_W-1:0] skip_cnt_q,    skip_cnt_d;
  logic [ADDR_W-1:0] addr_q,        addr_d;
  logic              capture_en_q,  capture_en_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_end_q,   frame_end_d;
  logic              busy_q,        busy_d;

  logic vsyn_neg;
  logic req_valid;
  logic wr_fire;

`ifdef FRAME_CHECK_EN
  // Count saturates one past FRAME_WORDS so any overrun still compares unequal.
  localparam int CNT_W = $clog2(FRAME_WORDS + 2);
  localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(FRAME_WORDS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_WORDS + 1);

  logic [CNT_W-1:0] word_cnt_q,  word_cnt_d;
  logic             sat_q,       sat_d;
  logic             frame_err_q, frame_err_d;
`endif

  always_comb begin
    vsyn_neg  = ~vsyn_d1_q & vsyn_d2_q;
    req_valid = (deb_cnt_q == DEB_MAX);
    wr_fire   = bus.data_16b_en & capture_en_q;

    // NOTE: every _d gets a default before any branch, so no path leaves it unassigned (no latches).
    state_d       = state_q;
    cfg_meta_d    = bus.cfg_done;
    cfg_sync_d    = cfg_meta_q;
    vsyn_d1_d     = bus.cmos_vsyn;
    vsyn_d2_d     = vsyn_d1_q;
    deb_cnt_d     = deb_cnt_q;
    consumed_d    = consumed_q;
    skip_cnt_d    = skip_cnt_q;
    addr_d        = addr_q;
    capture_en_d  = capture_en_q;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
`ifdef FRAME_CHECK_EN
    word_cnt_d    = word_cnt_q;
    sat_d         = sat_q;
    frame_err_d   = frame_err_q;
`endif

    if (bus.frame_en) begin
      deb_cnt_d = '0;
    end else if (!req_valid) begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end

    // The address sticks at the top instead of wrapping over earlier words.
    if (wr_fire && (addr_q != ADDR_MAX)) begin
      addr_d = addr_q + 1'b1;
    end

`ifdef FRAME_CHECK_EN
    if (wr_fire) begin
      if (word_cnt_q != CNT_MAX) word_cnt_d = word_cnt_q + 1'b1;
      if (addr_q == ADDR_MAX)    sat_d      = 1'b1;
    end
`endif

    if ((state_q != S_IDLE) && !cfg_sync_q) begin
      state_d      = S_IDLE;
      skip_cnt_d   = '0;
      capture_en_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          skip_cnt_d = '0;
          if (cfg_sync_q) state_d = S_WARMUP;
        end
        S_WARMUP: begin
          if (vsyn_neg) begin
            if (skip_cnt_q == SKIP_LAST) begin
              state_d    = S_READY;
              skip_cnt_d = '0;
            end else begin
              skip_cnt_d = skip_cnt_q + 1'b1;
            end
          end
        end
        S_READY: begin
          if (req_valid && !consumed_q) begin
            state_d    = S_ARM;
            consumed_d = 1'b1;
          end
        end
        S_ARM: begin
          if (vsyn_neg) begin
            state_d       = S_CAPTURE;
            capture_en_d  = 1'b1;
            frame_start_d = 1'b1;
            addr_d        = '0;
`ifdef FRAME_CHECK_EN
            word_cnt_d    = '0;
            sat_d         = 1'b0;
`endif
          end
        end
        S_CAPTURE: begin
          if (vsyn_neg) begin
            state_d      = S_WAIT_PROC;
            capture_en_d = 1'b0;
            frame_end_d  = 1'b1;
`ifdef FRAME_CHECK_EN
            // Uses the next-count values so a word in this final cycle is included.
            frame_err_d  = (word_cnt_d != CNT_EXP) | sat_d;
`endif
          end
        end
        S_WAIT_PROC: begin
          if (bus.proc_done) state_d = S_READY;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // A request is re-armed only after frame_en has been released for a cycle.
    if (bus.frame_en) consumed_d = 1'b0;

    busy_d = (state_d != S_READY);
  end

  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cfg_meta_q    <= 1'b0;
      cfg_sync_q    <= 1'b0;
      vsyn_d1_q     <= 1'b0;
      vsyn_d2_q     <= 1'b0;
      deb_cnt_q     <= '0;
      consumed_q    <= 1'b0;
      skip_cnt_q    <= '0;
      addr_q        <= '0;
      capture_en_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      busy_q        <= 1'b0;
`ifdef FRAME_CHECK_EN
      word_cnt_q    <= '0;
      sat_q         <= 1'b0;
      frame_err_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cfg_meta_q    <= cfg_meta_d;
      cfg_sync_q    <= cfg_sync_d;
      vsyn_d1_q     <= vsyn_d1_d;
      vsyn_d2_q     <= vsyn_d2_d;
      deb_cnt_q     <= deb_cnt_d;
      consumed_q    <= consumed_d;
      skip_cnt_q    <= skip_cnt_d;
      addr_q        <= addr_d;
      capture_en_q  <= capture_en_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      busy_q        <= busy_d;
`ifdef FRAME_CHECK_EN
      word_cnt_q    <= word_cnt_d;
      sat_q         <= sat_d;
      frame_err_q   <= frame_err_d;
`endif
    end
  end

  assign bus.capture_en  = capture_en_q;
  assign bus.wr_addr     = addr_q;
  assign bus.wr_en       = wr_fire;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_end   = frame_end_q;
  assign bus.busy        = busy_q;
`ifdef FRAME_CHECK_EN
  assign bus.frame_err   = frame_err_q;
`else
  assign bus.frame_err   = 1'b0;
`endif

endmodule

// File: tb/tb_cam_frame_sched.sv
// Self-checking bench for cam_frame_sched: directed scenarios plus randomized frames
// scored against a transaction-level model of requests, writes and frame errors.
module tb_cam_frame_sched;

  localparam int SKIP = 2;
  localparam int DEB  = 4;
  localparam int FW   = 16;
  localparam int AW   = 5;
  localparam int AMAX = (1 << AW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cam_frame_sched_if #(.ADDR_W(AW)) bus ();

  cam_frame_sched #(
    .SKIP_FRAMES(SKIP),
    .DEBOUNCE   (DEB),
    .FRAME_WORDS(FW),
    .ADDR_W     (AW)
  ) dut (
    .cmos_pclk(clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  int n_wr, n_start, n_end;
  int wr_addrs[$];
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      n_wr++;
      wr_addrs.push_back(int'(bus.wr_addr));
    end
    if (bus.frame_start === 1'b1) n_start++;
    if (bus.frame_end === 1'b1)   n_end++;
  end

  task automatic clear_mon();
    n_wr = 0;
    n_start = 0;
    n_end = 0;
    wr_addrs.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: expected frame_err and address of the i-th word of a frame.
  function automatic logic model_err(input int n);
`ifdef FRAME_CHECK_EN
    return (n != FW) || (n > AMAX);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_addr(input int i);
    return (i > AMAX) ? AMAX : i;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_capture_en"},  bus.capture_en, 0);
    check({tag, "_wr_addr"},     bus.wr_addr, 0);
    check({tag, "_wr_en"},       bus.wr_en, 0);
    check({tag, "_frame_start"}, bus.frame_start, 0);
    check({tag, "_frame_end"},   bus.frame_end, 0);
    check({tag, "_frame_err"},   bus.frame_err, 0);
    check({tag, "_busy"},        bus.busy, 0);
  endtask

  // Raise cfg_done and deliver SKIP VSYNC pulses; READY one cycle after the last falling edge.
  task automatic warmup();
    clear_mon();
    bus.cfg_done = 1'b1;
    tick(4);
    check("warm_busy_pre", bus.busy, 1);
    for (int i = 0; i < SKIP; i++) begin
      bus.cmos_vsyn = 1'b1;
      tick(3);
      bus.cmos_vsyn = 1'b0;
      tick(1);
      check("warm_busy_negcyc", bus.busy, 1);
      tick(1);
      check($sformatf("warm_busy_after_edge%0d", i + 1), bus.busy, (i == SKIP - 1) ? 0 : 1);
    end
    check("warm_no_writes", n_wr, 0);
  endtask

  task automatic request(input int low_cycles);
    bus.frame_en = 1'b0;
    tick(low_cycles);
    bus.frame_en = 1'b1;
    tick(2);
  endtask

  // From ARM: stray strobes (never written), then the VSYNC that opens capture.
  task automatic start_frame();
    int n_arm;
    n_arm = $urandom_range(0, 3);
    for (int i = 0; i < n_arm; i++) begin
      bus.data_16b_en = 1'b1;
      tick(1);
      bus.data_16b_en = 1'b0;
      tick(1);
    end
    bus.cmos_vsyn = 1'b1;
    tick(3);
    bus.cmos_vsyn = 1'b0;
    tick(1);
    bus.data_16b_en = 1'($urandom_range(0, 1));
    tick(1);
    bus.data_16b_en = 1'b0;
    check("start_pulse", bus.frame_start, 1);
    check("start_capture_en", bus.capture_en, 1);
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      tick($urandom_range(0, 2));
      bus.data_16b_en = 1'b1;
      tick(1);
      bus.data_16b_en = 1'b0;
    end
  endtask

  task automatic run_frame(input int n, input bit exit_strobe, input bit proc_pre);
    bit es;
    es = exit_strobe && (n > 0);
    clear_mon();
    start_frame();
    strobes(es ? n - 1 : n);
    tick(1);
    bus.cmos_vsyn = 1'b1;
    tick(3);
    if (proc_pre) bus.proc_done = 1'b1;
    bus.cmos_vsyn = 1'b0;
    tick(1);
    if (es) bus.data_16b_en = 1'b1;
    tick(1);
    bus.data_16b_en = 1'b0;
    check("end_pulse", bus.frame_end, 1);
    check("end_capture_en", bus.capture_en, 0);
    check("end_busy", bus.busy, 1);
    check("frame_err", bus.frame_err, model_err(n));
    if (!proc_pre) begin
      tick($urandom_range(0, 3));
      check("wait_proc_busy", bus.busy, 1);
      bus.proc_done = 1'b1;
    end
    tick(1);
    bus.proc_done = 1'b0;
    check("ready_after_proc", bus.busy, 0);
    check("n_writes", n_wr, n);
    check("n_frame_start", n_start, 1);
    check("n_frame_end", n_end, 1);
    for (int i = 0; i < n && i < wr_addrs.size(); i++) begin
      check($sformatf("addr_word%0d", i), wr_addrs[i], model_addr(i));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, n;
    bus.cfg_done    = 1'b0;
    bus.cmos_vsyn   = 1'b0;
    bus.frame_en    = 1'b1;
    bus.proc_done   = 1'b0;
    bus.data_16b_en = 1'b0;
    clear_mon();

    // Reset state
    #3;
    check_all_zero("reset");
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("idle_busy", bus.busy, 1);
    tick(5);
    check("idle_without_cfg", bus.busy, 1);

    warmup();

    // Normal frame with exactly FRAME_WORDS words
    request(DEB);
    check("arm_on_debounce", bus.busy, 1);
    run_frame(FW, 1'b0, 1'b0);

    // Glitch rejection
    request(DEB - 1);
    check("glitch_no_arm", bus.busy, 0);

    // Long hold: one capture only, then a re-request after release
    bus.frame_en = 1'b0;
    tick(20);
    check("hold_arm", bus.busy, 1);
    run_frame(FW, 1'b1, 1'b1);
    tick(10);
    check("hold_no_rearm", bus.busy, 0);
    bus.frame_en = 1'b1;
    tick(1);
    request(DEB);
    check("rearm_after_release", bus.busy, 1);
    run_frame(FW, 1'b0, 1'b0);

    // Short frame sets frame_err, correct frame clears it
    request(DEB);
    run_frame(FW - 1, 1'b0, 1'b0);
    request(DEB);
    run_frame(FW, 1'b1, 1'b0);

    // Randomized requests and frames
    for (int k = 0; k < 12; k++) begin
      len = $urandom_range(1, 7);
      request(len);
      check($sformatf("rnd%0d_arm", k), bus.busy, (len >= DEB) ? 1 : 0);
      if (len >= DEB) begin
        n = ($urandom_range(0, 1) == 1) ? $urandom_range(FW - 2, FW + 2) : $urandom_range(0, 40);
        run_frame(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    // Address saturation
    request(DEB);
    run_frame(40, 1'b1, 1'b0);

    // cfg_done loss mid-capture
    request(DEB);
    clear_mon();
    start_frame();
    strobes(5);
    bus.cfg_done = 1'b0;
    tick(2);
    check("abort_sync_latency", bus.capture_en, 1);
    tick(1);
    check("abort_capture_off", bus.capture_en, 0);
    check("abort_busy", bus.busy, 1);
    tick(5);
    check("abort_no_frame_end", n_end, 0);
    check("abort_writes", n_wr, 5);
    warmup();
    request(DEB);
    run_frame(FW, 1'b0, 1'b0);

    // Asynchronous reset mid-frame, after a frame that left frame_err set when checking is on
    request(DEB);
    run_frame(FW + 3, 1'b0, 1'b0);
    request(DEB);
    start_frame();
    strobes(3);
    bus.data_16b_en = 1'b1;
    check("pre_reset_wr_en", bus.wr_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    bus.data_16b_en = 1'b0;
    tick(2);
    rst_n = 1'b1;
    warmup();
    request(DEB);
    run_frame(FW, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
